temp_sensor_reader: RTL and testbench

Serial front end that polls the external temperature sensor and presents a stable 5-bit temperature word to the heating/cooling controller. It sits between the board-level sensor pins and the controller's `temperature_0..temperature_4` inputs, with bit 4 driving `temperature_0` as the MSB. It runs a fixed SPI-style read frame every sample period and validates each frame against a sync pattern. It flags persistent sensor failure.

---
 rtl/temp_sensor_pkg.sv | 20 ++
 rtl/temp_sensor_reader_sclk_gen.sv | 51 +++++
 rtl/temp_sensor_reader.sv | 162 ++++++++++++++++
 tb/tb_temp_sensor_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_sensor_pkg.sv
// rtl/temp_sensor_pkg.sv - shared constants, FSM state type and frame check for the sensor reader
package temp_sensor_pkg;

  localparam int         FRAME_BITS   = 8;
  localparam logic [2:0] SYNC_PATTERN = 3'b101;
  localparam logic [4:0] TEMP_RESET   = 5'd20;
  localparam int         FAULT_LIMIT  = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT,
    CHECK
  } state_e;

  function automatic logic frame_ok(input logic [FRAME_BITS-1:0] frame);
    return frame[2:0] == SYNC_PATTERN;
  endfunction

endpackage

// File: rtl/temp_sensor_reader_sclk_gen.sv
// rtl/temp_sensor_reader_sclk_gen.sv - sensor clock half-period divider with enable and edge strobes
module sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int              DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sclk_q, sclk_d;
  logic             toggle;

  // Strobes fire in the cycle before the edge that moves sclk, so a consumer
  // acting on them updates on the same clk edge as the pin.
  always_comb begin
    toggle    = en && (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    if (!en) begin
      div_cnt_d = '0;
      sclk_d    = 1'b0;
    end else if (toggle) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk = sclk_q;
  assign rise = toggle & ~sclk_q;
  assign fall = toggle & sclk_q;

endmodule

// File: rtl/temp_sensor_reader.sv
// rtl/temp_sensor_reader.sv - periodic serial sensor poll, sync validation and fault tracking
module temp_sensor_reader
  import temp_sensor_pkg::*;
#(
  parameter int SCLK_DIV      = 2,
  parameter int SAMPLE_PERIOD = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_sdo,
  output logic       sensor_cs_n,
  output logic       sensor_sclk,
  output logic [4:0] temperature,
  output logic       temp_valid,
  output logic       frame_err,
  output logic       sensor_fault
);

  localparam int               CNT_W     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int               TAIL_W    = $clog2(SCLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'(SCLK_DIV);

  if (SCLK_DIV < 1) begin : g_bad_div
    $error("SCLK_DIV must be at least 1");
  end
  if (SAMPLE_PERIOD <= 17 * SCLK_DIV + 1) begin : g_bad_period
    $error("SAMPLE_PERIOD must exceed 17*SCLK_DIV+1");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        period_q, period_d;
  logic [3:0]              fall_cnt_q, fall_cnt_d;
  logic [TAIL_W-1:0]       tail_q, tail_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic [4:0]              temp_q, temp_d;
  logic                    temp_valid_q, temp_valid_d;
  logic                    frame_err_q, frame_err_d;
  logic [1:0]              err_cnt_q, err_cnt_d;
  logic                    fault_q, fault_d;
  logic                    cs_n_q, cs_n_d;

  logic                    sclk_en;
  logic                    sclk_rise;
  logic                    sclk_fall;

  assign sclk_en = (state_q == START) ||
                   ((state_q == SHIFT) && (fall_cnt_q != 4'(FRAME_BITS)));

  sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sclk_en),
    .sclk  (sensor_sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_comb begin
    state_d      = state_q;
    period_d     = (period_q == CNT_LAST) ? '0 : period_q + CNT_W'(1);
    fall_cnt_d   = fall_cnt_q;
    tail_d       = tail_q;
    shift_d      = shift_q;
    temp_d       = temp_q;
    temp_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    err_cnt_d    = err_cnt_q;
    fault_d      = fault_q;

    if (sclk_rise) begin
      shift_d = {shift_q[FRAME_BITS-2:0], sensor_sdo};
    end
    if (sclk_fall) begin
      fall_cnt_d = fall_cnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        fall_cnt_d = '0;
        tail_d     = '0;
        if (period_q == '0) begin
          state_d = START;
        end
      end
      START: begin
        if (sclk_rise) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Low tail counts from the cycle holding the final fall, giving a
        // 17*SCLK_DIV+1 cycle chip-select window.
        if (fall_cnt_q == 4'(FRAME_BITS)) begin
          if (tail_q == TAIL_LAST) begin
            state_d = CHECK;
          end else begin
            tail_d = tail_q + TAIL_W'(1);
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok(shift_q)) begin
          temp_d       = shift_q[FRAME_BITS-1:3];
          temp_valid_d = 1'b1;
          err_cnt_d    = '0;
          fault_d      = 1'b0;
        end else begin
          frame_err_d = 1'b1;
          if (err_cnt_q != 2'(FAULT_LIMIT)) begin
            err_cnt_d = err_cnt_q + 2'd1;
          end
          if (err_cnt_d == 2'(FAULT_LIMIT)) begin
            fault_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    cs_n_d = !((state_d == START) || (state_d == SHIFT));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      period_q     <= '0;
      fall_cnt_q   <= '0;
      tail_q       <= '0;
      shift_q      <= '0;
      temp_q       <= TEMP_RESET;
      temp_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= '0;
      fault_q      <= 1'b0;
      cs_n_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      fall_cnt_q   <= fall_cnt_d;
      tail_q       <= tail_d;
      shift_q      <= shift_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
      fault_q      <= fault_d;
      cs_n_q       <= cs_n_d;
    end
  end

  // Board wiring: temperature[4] feeds the controller's temperature_0 (MSB).
  assign temperature  = temp_q;
  assign temp_valid   = temp_valid_q;
  assign frame_err    = frame_err_q;
  assign sensor_fault = fault_q;
  assign sensor_cs_n  = cs_n_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// tb/tb_temp_sensor_reader.sv - scoreboard bench with a serial sensor model for temp_sensor_reader
module tb_temp_sensor_reader;

  localparam int SCLK_DIV      = 2;
  localparam int SAMPLE_PERIOD = 64;
  localparam int RESULT_LAT    = 17 * SCLK_DIV + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor_sdo = 1'b0;
  logic       sensor_cs_n;
  logic       sensor_sclk;
  logic [4:0] temperature;
  logic       temp_valid;
  logic       frame_err;
  logic       sensor_fault;

  temp_sensor_reader #(
    .SCLK_DIV      (SCLK_DIV),
    .SAMPLE_PERIOD (SAMPLE_PERIOD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sensor_sdo   (sensor_sdo),
    .sensor_cs_n  (sensor_cs_n),
    .sensor_sclk  (sensor_sclk),
    .temperature  (temperature),
    .temp_valid   (temp_valid),
    .frame_err    (frame_err),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       good;
    logic [4:0] temp;
    logic       fault;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       sb_q[$];
  int         cs_falls[$];
  logic [7:0] next_frame = 8'b10110_101;
  logic [7:0] cur_frame = 8'h00;
  int         bit_idx = 0;
  logic [4:0] model_temp = 5'd20;
  logic [4:0] last_temp = 5'd20;
  int         model_errs = 0;
  int         cyc = 0;
  int         cs_fall_cyc = 0;
  int         rise_count = 0;
  int         frames_started = 0;
  int         results_seen = 0;
  int         err_pulses = 0;
  int         valid_pulses = 0;
  logic       prev_cs = 1'b1;
  logic       prev_sclk = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sensor model: presents bit 7 at chip select, shifts on each sclk fall,
  // and pushes the expected outcome of the frame it is about to send.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
    end else begin
      if (prev_cs && !sensor_cs_n) begin
        cur_frame  = next_frame;
        bit_idx    = 7;
        sensor_sdo = cur_frame[7];
        cs_fall_cyc = cyc;
        cs_falls.push_back(cyc);
        rise_count = 0;
        frames_started++;
        if (cur_frame[2:0] == 3'b101) begin
          model_temp = cur_frame[7:3];
          model_errs = 0;
        end else if (model_errs < 3) begin
          model_errs++;
        end
        e.good  = (cur_frame[2:0] == 3'b101);
        e.temp  = model_temp;
        e.fault = (model_errs >= 3);
        sb_q.push_back(e);
      end else if (prev_sclk && !sensor_sclk && !sensor_cs_n && bit_idx > 0) begin
        bit_idx--;
        sensor_sdo = cur_frame[bit_idx];
      end
      if (!prev_sclk && sensor_sclk) rise_count++;
      prev_cs   = sensor_cs_n;
      prev_sclk = sensor_sclk;
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      last_temp = 5'd20;
    end else if (temp_valid || frame_err) begin
      if (temp_valid) valid_pulses++;
      if (frame_err) err_pulses++;
      results_seen++;
      checks++;
      if (temp_valid && frame_err) begin
        errors++;
        $display("FAIL pulse_excl: temp_valid=%b frame_err=%b both high", temp_valid, frame_err);
      end
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: result pulse at cycle %0d with no frame pending", cyc);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (temp_valid !== e.good) begin
          errors++;
          $display("FAIL sb_kind: temp_valid=%b required %b", temp_valid, e.good);
        end
        checks++;
        if (temperature !== e.temp) begin
          errors++;
          $display("FAIL sb_temp: temperature=%0d required %0d", temperature, e.temp);
        end
        checks++;
        if (sensor_fault !== e.fault) begin
          errors++;
          $display("FAIL sb_fault: sensor_fault=%b required %b", sensor_fault, e.fault);
        end
        checks++;
        if (cyc - cs_fall_cyc !== RESULT_LAT) begin
          errors++;
          $display("FAIL sb_latency: result at frame cycle %0d required %0d", cyc - cs_fall_cyc, RESULT_LAT);
        end
        checks++;
        if (rise_count !== 8) begin
          errors++;
          $display("FAIL sb_rises: %0d sclk rising edges required 8", rise_count);
        end
        last_temp = e.temp;
      end
    end else begin
      checks++;
      if (temperature !== last_temp) begin
        errors++;
        $display("FAIL temp_stable: temperature=%0d changed without temp_valid, required %0d", temperature, last_temp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic wait_results(input int target);
    int t = 0;
    while (results_seen < target && t < 120) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (results_seen < target) begin
      errors++;
      $display("FAIL result_timeout: results_seen=%0d required %0d", results_seen, target);
    end
  endtask

  task automatic run_frame(input logic [7:0] f);
    int start;
    int t = 0;
    next_frame = f;
    start = frames_started;
    while (frames_started == start && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (frames_started == start) begin
      errors++;
      $display("FAIL frame_timeout: no cs_n fall within %0d cycles, required one", t);
    end
    wait_results(frames_started);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sensor_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: %b required 1", sensor_cs_n); end
    checks++;
    if (sensor_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: %b required 0", sensor_sclk); end
    checks++;
    if (temperature !== 5'd20) begin errors++; $display("FAIL reset_temp: %0d required 20", temperature); end
    checks++;
    if (temp_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: valid=%b err=%b required 0 0", temp_valid, frame_err);
    end
    checks++;
    if (sensor_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: %b required 0", sensor_fault); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sensor_cs_n !== 1'b0) begin errors++; $display("FAIL first_frame: cs_n=%b required 0 on first cycle", sensor_cs_n); end
  endtask

  task automatic test_good_frame();
    int v0;
    wait_results(1);
    v0 = valid_pulses;
    run_frame(8'b10110_101);
    checks++;
    if (temperature !== 5'd22) begin errors++; $display("FAIL good_temp: %0d required 22", temperature); end
    checks++;
    if (valid_pulses - v0 !== 1) begin errors++; $display("FAIL good_valid_count: %0d required 1", valid_pulses - v0); end
  endtask

  task automatic test_boundary();
    int e0 = err_pulses;
    int v0 = valid_pulses;
    run_frame(8'b00000_101);
    checks++;
    if (temperature !== 5'd0) begin errors++; $display("FAIL bound_zero: %0d required 0", temperature); end
    run_frame(8'b11111_101);
    checks++;
    if (temperature !== 5'd31) begin errors++; $display("FAIL bound_max: %0d required 31", temperature); end
    checks++;
    if (err_pulses !== e0 || valid_pulses - v0 !== 2) begin
      errors++; $display("FAIL bound_pulses: err=%0d valid=%0d required 0 2", err_pulses - e0, valid_pulses - v0);
    end
  endtask

  task automatic test_fault();
    int e0 = err_pulses;
    run_frame(8'b10010_000);
    checks++;
    if (temperature !== 5'd31) begin errors++; $display("FAIL fault_hold: %0d required 31", temperature); end
    checks++;
    if (err_pulses - e0 !== 1 || sensor_fault !== 1'b0) begin
      errors++; $display("FAIL fault_first: err=%0d fault=%b required 1 0", err_pulses - e0, sensor_fault);
    end
    run_frame(8'b10010_000);
    run_frame(8'b10010_000);
    checks++;
    if (sensor_fault !== 1'b1) begin errors++; $display("FAIL fault_set: %b required 1", sensor_fault); end
    run_frame(8'b10011_101);
    checks++;
    if (temperature !== 5'd19 || sensor_fault !== 1'b0) begin
      errors++; $display("FAIL fault_clear: temp=%0d fault=%b required 19 0", temperature, sensor_fault);
    end
  endtask

  task automatic test_period();
    int start;
    int t;
    cs_falls.delete();
    for (int i = 0; i < 10; i++) begin
      next_frame = {5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0) ? 3'b011 : 3'b101};
      start = frames_started;
      t = 0;
      while (frames_started == start && t < 200) begin
        @(negedge clk);
        t++;
      end
    end
    wait_results(frames_started);
    checks++;
    if (cs_falls.size() !== 10) begin
      errors++; $display("FAIL period_count: %0d cs_n falls required 10", cs_falls.size());
    end else begin
      for (int i = 1; i < 10; i++) begin
        checks++;
        if (cs_falls[i] - cs_falls[i-1] !== SAMPLE_PERIOD) begin
          errors++; $display("FAIL period_gap: %0d cycles required %0d", cs_falls[i] - cs_falls[i-1], SAMPLE_PERIOD);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int start = frames_started;
    int t = 0;
    next_frame = 8'b10110_101;
    while (!(frames_started != start && rise_count == 4 && sensor_sclk === 1'b1) && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 300) begin errors++; $display("FAIL mid_timeout: 4th sclk high phase not seen"); end
    rst_n = 1'b0;
    sb_q.delete();
    model_temp = 5'd20;
    model_errs = 0;
    @(posedge clk);
    #1;
    checks++;
    if (sensor_cs_n !== 1'b1 || sensor_sclk !== 1'b0) begin
      errors++; $display("FAIL mid_pins: cs_n=%b sclk=%b required 1 0", sensor_cs_n, sensor_sclk);
    end
    checks++;
    if (temperature !== 5'd20 || sensor_fault !== 1'b0) begin
      errors++; $display("FAIL mid_outputs: temp=%0d fault=%b required 20 0", temperature, sensor_fault);
    end
    repeat (2) @(negedge clk);
    frames_started = 0;
    results_seen   = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sensor_cs_n !== 1'b0) begin errors++; $display("FAIL mid_restart: cs_n=%b required 0", sensor_cs_n); end
    wait_results(1);
    checks++;
    if (temperature !== 5'd22) begin errors++; $display("FAIL mid_after: temp=%0d required 22", temperature); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_boundary();
    test_fault();
    test_period();
    test_reset_mid_frame();
    checks++;
    if (sb_q.size() !== 0) begin
      errors++; $display("FAIL sb_leftover: %0d expected results never produced, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
